// File: rtl/clk_div_multi.sv
// ---------------------------------------------------------------------------
// clk_div_multi
//   Multi-channel programmable clock-enable generator. Everything runs on clk;
//   no derived clocks are created. Each channel produces a one-cycle tick
//   strobe every Neff cycles (Neff = div, or 1 when div is 0) and a registered
//   square wave that toggles on every tick. The square wave is meant for LEDs
//   and pins only and is never used as a clock.
//   A divisor written to a running channel is held in a shadow register and
//   applied at the next terminal count, so the period in progress always
//   completes with its old length.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous reset, active-low
//   cfg_we    configuration write strobe
//   cfg_ch    target channel of the write (values >= NUM_CH are ignored)
//   cfg_en    new enable for the target channel
//   cfg_div   new divisor for the target channel
//   sync_clr  restart every enabled channel in phase
//   tick      per-channel one-cycle strobe
//   sq_out    per-channel square wave, period 2*Neff
//   pending   per-channel flag: divisor accepted but not yet applied
// ---------------------------------------------------------------------------
module clk_div_multi #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 27,
    parameter int DEF_DIV = 67108864,
    parameter int DEF_EN  = 1
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         cfg_we,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic                                         cfg_en,
    input  logic [CNT_W-1:0]                             cfg_div,
    input  logic                                         sync_clr,
    output logic [NUM_CH-1:0]                            tick,
    output logic [NUM_CH-1:0]                            sq_out,
    output logic [NUM_CH-1:0]                            pending
);

    localparam logic [CNT_W-1:0]  DEF_DIV_C = CNT_W'(DEF_DIV);
    localparam logic [NUM_CH-1:0] DEF_EN_C  = (DEF_EN != 0) ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}};
    localparam logic [CNT_W-1:0]  ZERO_C    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  ONE_C     = CNT_W'(1);

    // Per-channel state
    logic [CNT_W-1:0]  cnt_r  [NUM_CH];
    logic [CNT_W-1:0]  div_r  [NUM_CH];
    logic [CNT_W-1:0]  shd_r  [NUM_CH];
    logic [NUM_CH-1:0] en_r;
    logic [NUM_CH-1:0] pend_r;
    logic [NUM_CH-1:0] tick_r;
    logic [NUM_CH-1:0] sq_r;

    // Next-state values
    logic [CNT_W-1:0]  cnt_nx_s [NUM_CH];
    logic [CNT_W-1:0]  div_nx_s [NUM_CH];
    logic [CNT_W-1:0]  shd_nx_s [NUM_CH];
    logic [NUM_CH-1:0] en_nx_s;
    logic [NUM_CH-1:0] pend_nx_s;
    logic [NUM_CH-1:0] tick_nx_s;
    logic [NUM_CH-1:0] sq_nx_s;

    // Decoded per-channel conditions
    logic [CNT_W-1:0]  last_s [NUM_CH];
    logic [NUM_CH-1:0] tc_s;
    logic [NUM_CH-1:0] wr_s;

    // Terminal-count and write-select decode for every channel
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            // Divisor 0 behaves like divisor 1: terminal count is cnt==0.
            if (div_r[i] == ZERO_C) begin
                last_s[i] = ZERO_C;
            end else begin
                last_s[i] = div_r[i] - ONE_C;
            end
            tc_s[i] = en_r[i] & (cnt_r[i] == last_s[i]);
            wr_s[i] = cfg_we & (int'(cfg_ch) == i) & (int'(cfg_ch) < NUM_CH);
        end
    end

    // Next-state logic: config write beats sync_clr, sync_clr beats terminal count
    always_comb begin
        en_nx_s   = en_r;
        pend_nx_s = pend_r;
        tick_nx_s = {NUM_CH{1'b0}};
        sq_nx_s   = sq_r;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_nx_s[i] = cnt_r[i];
            div_nx_s[i] = div_r[i];
            shd_nx_s[i] = shd_r[i];
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_s[i]) begin
                if (!cfg_en) begin
                    // Stop: load divisor at once and park the channel.
                    en_nx_s[i]   = 1'b0;
                    div_nx_s[i]  = cfg_div;
                    cnt_nx_s[i]  = ZERO_C;
                    pend_nx_s[i] = 1'b0;
                    sq_nx_s[i]   = 1'b0;
                end else if (!en_r[i]) begin
                    // Start a stopped channel from a fresh period.
                    en_nx_s[i]  = 1'b1;
                    div_nx_s[i] = cfg_div;
                    cnt_nx_s[i] = ZERO_C;
                end else if (tc_s[i]) begin
                    // Write lands on the terminal count: the new divisor
                    // shapes the very next period, no pending phase.
                    div_nx_s[i]  = cfg_div;
                    pend_nx_s[i] = 1'b0;
                    cnt_nx_s[i]  = ZERO_C;
                    tick_nx_s[i] = 1'b1;
                    sq_nx_s[i]   = ~sq_r[i];
                end else begin
                    // Running mid-period: defer, last write wins.
                    shd_nx_s[i]  = cfg_div;
                    pend_nx_s[i] = 1'b1;
                    cnt_nx_s[i]  = cnt_r[i] + ONE_C;
                end
            end else if (sync_clr && en_r[i]) begin
                cnt_nx_s[i]  = ZERO_C;
                sq_nx_s[i]   = 1'b0;
                pend_nx_s[i] = 1'b0;
                if (pend_r[i]) begin
                    div_nx_s[i] = shd_r[i];
                end else begin
                    div_nx_s[i] = div_r[i];
                end
            end else if (tc_s[i]) begin
                cnt_nx_s[i]  = ZERO_C;
                tick_nx_s[i] = 1'b1;
                sq_nx_s[i]   = ~sq_r[i];
                pend_nx_s[i] = 1'b0;
                if (pend_r[i]) begin
                    div_nx_s[i] = shd_r[i];
                end else begin
                    div_nx_s[i] = div_r[i];
                end
            end else if (en_r[i]) begin
                cnt_nx_s[i] = cnt_r[i] + ONE_C;
            end else begin
                cnt_nx_s[i] = cnt_r[i];
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_r   <= DEF_EN_C;
            pend_r <= {NUM_CH{1'b0}};
            tick_r <= {NUM_CH{1'b0}};
            sq_r   <= {NUM_CH{1'b0}};
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i] <= ZERO_C;
                div_r[i] <= DEF_DIV_C;
                shd_r[i] <= ZERO_C;
            end
        end else begin
            en_r   <= en_nx_s;
            pend_r <= pend_nx_s;
            tick_r <= tick_nx_s;
            sq_r   <= sq_nx_s;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i] <= cnt_nx_s[i];
                div_r[i] <= div_nx_s[i];
                shd_r[i] <= shd_nx_s[i];
            end
        end
    end

    assign tick    = tick_r;
    assign sq_out  = sq_r;
    assign pending = pend_r;

endmodule
